// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and types for the ID-stage operand fetch block.
// Forwarding is compiled in only when OPFETCH_BYPASS_EN is defined.
package opfetch_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 32;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM,
    FWD_EX
  } fwd_src_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } producer_t;
endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode-side, regfile, producer and EX-side signals of the operand fetch stage.
// The slave modport is the stage itself; the master modport is its environment.
interface operand_fetch_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [ADDR_W-1:0] in_rj;
  logic [ADDR_W-1:0] in_rk;
  logic              in_use_rj;
  logic              in_use_rk;
  logic [CTRL_W-1:0] in_ctrl;

  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;

  logic              ex_we;
  logic [ADDR_W-1:0] ex_waddr;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_is_load;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [DATA_W-1:0] out_src1;
  logic [DATA_W-1:0] out_src2;
  logic [CTRL_W-1:0] out_ctrl;
  logic [31:0]       stall_cnt;

  modport master (
    output in_valid, in_pc, in_rj, in_rk, in_use_rj, in_use_rk, in_ctrl,
    output rf_rdata1, rf_rdata2,
    output ex_we, ex_waddr, ex_wdata, ex_is_load,
    output mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata,
    output out_ready,
    input  in_ready, rf_raddr1, rf_raddr2,
    input  out_valid, out_pc, out_src1, out_src2, out_ctrl, stall_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_rj, in_rk, in_use_rj, in_use_rk, in_ctrl,
    input  rf_rdata1, rf_rdata2,
    input  ex_we, ex_waddr, ex_wdata, ex_is_load,
    input  mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata,
    input  out_ready,
    output in_ready, rf_raddr1, rf_raddr2,
    output out_valid, out_pc, out_src1, out_src2, out_ctrl, stall_cnt
  );
endinterface

// File: rtl/operand_fetch_stage_fwd_mux.sv
// Per-operand producer match and EX > MEM > WB > regfile priority select.
// Without OPFETCH_BYPASS_EN the operand always comes from the regfile.
module opfetch_fwd_mux
  import opfetch_pkg::*;
(
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_use,
  input  producer_t         i_ex,
  input  producer_t         i_mem,
  input  producer_t         i_wb,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output logic              o_match_ex,
  output logic              o_match_any,
  output logic [DATA_W-1:0] o_operand
);
  logic w_nonzero;
  logic w_match_ex;
  logic w_match_mem;
  logic w_match_wb;

  // r0 is hard-wired zero, so a write aimed at it never produces a hazard.
  assign w_nonzero   = (i_raddr != '0);
  assign w_match_ex  = i_use & w_nonzero & i_ex.we  & (i_ex.waddr  == i_raddr);
  assign w_match_mem = i_use & w_nonzero & i_mem.we & (i_mem.waddr == i_raddr);
  assign w_match_wb  = i_use & w_nonzero & i_wb.we  & (i_wb.waddr  == i_raddr);

  assign o_match_ex  = w_match_ex;
  assign o_match_any = w_match_ex | w_match_mem | w_match_wb;

`ifdef OPFETCH_BYPASS_EN
  fwd_src_e w_sel;

  always_comb begin
    w_sel = FWD_RF;
    if (w_match_ex)       w_sel = FWD_EX;
    else if (w_match_mem) w_sel = FWD_MEM;
    else if (w_match_wb)  w_sel = FWD_WB;
  end

  // WB must be forwarded: the regfile write lands at the same edge we sample.
  always_comb begin
    o_operand = '0;
    if (i_use) begin
      case (w_sel)
        FWD_EX:  o_operand = i_ex.wdata;
        FWD_MEM: o_operand = i_mem.wdata;
        FWD_WB:  o_operand = i_wb.wdata;
        FWD_RF:  o_operand = i_rf_rdata;
      endcase
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^{i_ex.wdata, i_mem.wdata, i_wb.wdata};
  assign o_operand = i_use ? i_rf_rdata : '0;
`endif
endmodule

// File: rtl/operand_fetch_stage.sv
// ID-stage operand fetch: regfile read, RAW hazard resolution, ID->EX register.
// OPFETCH_BYPASS_EN selects forwarding (load-use stall only) vs. full interlock.
module operand_fetch_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 32
) (
  input logic                 clk,
  input logic                 resetn,
  input logic                 flush,
  operand_fetch_stage_if.slave bus
);
  import opfetch_pkg::*;

  producer_t         w_ex;
  producer_t         w_mem;
  producer_t         w_wb;
  logic [ADDR_W-1:0] w_raddr     [2];
  logic              w_use       [2];
  logic [DATA_W-1:0] w_rdata     [2];
  logic [DATA_W-1:0] w_opnd      [2];
  logic              w_match_ex  [2];
  logic              w_match_any [2];
  logic              w_hazard;
  logic              w_in_ready;
  logic              w_accept;

  logic              r_out_valid;
  logic [31:0]       r_out_pc;
  logic [DATA_W-1:0] r_out_src1;
  logic [DATA_W-1:0] r_out_src2;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [31:0]       r_stall_cnt;

  assign w_ex  = '{we: bus.ex_we,  waddr: bus.ex_waddr,  wdata: bus.ex_wdata};
  assign w_mem = '{we: bus.mem_we, waddr: bus.mem_waddr, wdata: bus.mem_wdata};
  assign w_wb  = '{we: bus.wb_we,  waddr: bus.wb_waddr,  wdata: bus.wb_wdata};

  assign w_raddr[0] = bus.in_rj;
  assign w_raddr[1] = bus.in_rk;
  assign w_use[0]   = bus.in_use_rj;
  assign w_use[1]   = bus.in_use_rk;
  assign w_rdata[0] = bus.rf_rdata1;
  assign w_rdata[1] = bus.rf_rdata2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      opfetch_fwd_mux u_fwd (
        .i_raddr     (w_raddr[gi]),
        .i_use       (w_use[gi]),
        .i_ex        (w_ex),
        .i_mem       (w_mem),
        .i_wb        (w_wb),
        .i_rf_rdata  (w_rdata[gi]),
        .o_match_ex  (w_match_ex[gi]),
        .o_match_any (w_match_any[gi]),
        .o_operand   (w_opnd[gi])
      );
    end
  endgenerate

`ifdef OPFETCH_BYPASS_EN
  // Only a load in EX cannot be forwarded yet; one bubble lets it reach MEM.
  logic w_unused;
  assign w_unused = w_match_any[0] ^ w_match_any[1];
  assign w_hazard = bus.ex_is_load & (w_match_ex[0] | w_match_ex[1]);
`else
  logic w_unused;
  assign w_unused = w_match_ex[0] ^ w_match_ex[1] ^ bus.ex_is_load;
  assign w_hazard = w_match_any[0] | w_match_any[1];
`endif

  assign w_in_ready = ~flush & ~w_hazard & (~r_out_valid | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_src1  <= '0;
      r_out_src2  <= '0;
      r_out_ctrl  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= bus.in_pc;
        r_out_src1  <= w_opnd[0];
        r_out_src2  <= w_opnd[1];
        r_out_ctrl  <= bus.in_ctrl;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (bus.in_valid & w_hazard & ~flush) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.rf_raddr1 = bus.in_rj;
  assign bus.rf_raddr2 = bus.in_rk;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pc    = r_out_pc;
  assign bus.out_src1  = r_out_src1;
  assign bus.out_src2  = r_out_src2;
  assign bus.out_ctrl  = r_out_ctrl;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage; expectations follow the build mode
// selected by OPFETCH_BYPASS_EN.
module tb_operand_fetch_stage;
  logic clk = 1'b0;
  logic resetn;
  logic flush;
  int   total = 0;
  int   bad = 0;
  int   exp_stall = 0;

  operand_fetch_stage_if #(.DATA_W(32), .ADDR_W(5), .CTRL_W(32)) bus ();

  operand_fetch_stage #(.DATA_W(32), .ADDR_W(5), .CTRL_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rj     = '0;
    bus.in_rk     = '0;
    bus.in_use_rj = 1'b0;
    bus.in_use_rk = 1'b0;
    bus.rf_rdata1 = '0;
    bus.rf_rdata2 = '0;
    bus.ex_we     = 1'b0;
    bus.ex_waddr  = '0;
    bus.ex_wdata  = '0;
    bus.ex_is_load = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    bus.wb_we     = 1'b0;
    bus.wb_waddr  = '0;
    bus.wb_wdata  = '0;
  endtask

  initial begin
    resetn        = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_pc     = '0;
    bus.in_ctrl   = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_src1", bus.out_src1, 0);
    chk("rst_out_ctrl", bus.out_ctrl, 0);

    // EX and MEM both write r5; EX is the younger value
    bus.ex_we = 1; bus.ex_waddr = 5; bus.ex_wdata = 32'hAA;
    bus.mem_we = 1; bus.mem_waddr = 5; bus.mem_wdata = 32'hBB;
    bus.rf_rdata1 = 32'h11;
    bus.in_valid = 1; bus.in_rj = 5; bus.in_use_rj = 1;
    bus.in_pc = 32'h100; bus.in_ctrl = 32'hC0DE;
    #1;
    chk("raddr1", bus.rf_raddr1, 5);
`ifndef OPFETCH_BYPASS_EN
    chk("raw_ex_ready", bus.in_ready, 0);
    tick(); exp_stall++;
    chk("raw_ex_stall", bus.stall_cnt, exp_stall);
    chk("raw_ex_noval", bus.out_valid, 0);
    bus.ex_we = 0; bus.mem_we = 0; bus.rf_rdata1 = 32'hAA;
    #1;
`endif
    chk("fwd_ready", bus.in_ready, 1);
    tick();
    chk("fwd_valid", bus.out_valid, 1);
    chk("fwd_src1", bus.out_src1, 32'hAA);
    chk("fwd_src2_unused", bus.out_src2, 0);
    chk("fwd_pc", bus.out_pc, 32'h100);
    chk("fwd_ctrl", bus.out_ctrl, 32'hC0DE);
    chk("fwd_stall", bus.stall_cnt, exp_stall);
    idle();
    tick();
    chk("drain_valid", bus.out_valid, 0);

    // load in EX feeding rk
    bus.ex_we = 1; bus.ex_is_load = 1; bus.ex_waddr = 7; bus.ex_wdata = 32'hDEAD;
    bus.in_valid = 1; bus.in_rk = 7; bus.in_use_rk = 1; bus.in_pc = 32'h104;
    #1;
    chk("lu_ready", bus.in_ready, 0);
    tick(); exp_stall++;
    chk("lu_stall", bus.stall_cnt, exp_stall);
    chk("lu_noval", bus.out_valid, 0);
    bus.ex_we = 0; bus.ex_is_load = 0;
    bus.mem_we = 1; bus.mem_waddr = 7; bus.mem_wdata = 32'h77;
    #1;
`ifndef OPFETCH_BYPASS_EN
    chk("lu_mem_ready", bus.in_ready, 0);
    tick(); exp_stall++;
    bus.mem_we = 0; bus.wb_we = 1; bus.wb_waddr = 7; bus.wb_wdata = 32'h77;
    #1;
    chk("lu_wb_ready", bus.in_ready, 0);
    tick(); exp_stall++;
    bus.wb_we = 0; bus.rf_rdata2 = 32'h77;
    #1;
`endif
    chk("lu_go_ready", bus.in_ready, 1);
    tick();
    chk("lu_valid", bus.out_valid, 1);
    chk("lu_src2", bus.out_src2, 32'h77);
    chk("lu_src1_unused", bus.out_src1, 0);
    chk("lu_stall_after", bus.stall_cnt, exp_stall);
    idle();
    tick();

    // WB write to r3 while the regfile still returns the old value
    bus.wb_we = 1; bus.wb_waddr = 3; bus.wb_wdata = 32'h1234;
    bus.in_valid = 1; bus.in_rj = 3; bus.in_use_rj = 1; bus.in_pc = 32'h108;
    #1;
`ifndef OPFETCH_BYPASS_EN
    chk("wb_ready", bus.in_ready, 0);
    tick(); exp_stall++;
    bus.wb_we = 0; bus.rf_rdata1 = 32'h1234;
    #1;
`endif
    chk("wb_go_ready", bus.in_ready, 1);
    tick();
    chk("wb_src1", bus.out_src1, 32'h1234);
    chk("wb_stall", bus.stall_cnt, exp_stall);

    // writes to r0 never forward or stall
    bus.wb_we = 1; bus.wb_waddr = 0; bus.wb_wdata = 32'hFFFF;
    bus.ex_we = 1; bus.ex_waddr = 0; bus.ex_wdata = 32'hEEEE;
    bus.in_rj = 0; bus.rf_rdata1 = 0; bus.in_pc = 32'h10C;
    #1;
    chk("r0_ready", bus.in_ready, 1);
    tick();
    chk("r0_src1", bus.out_src1, 0);
    chk("r0_pc", bus.out_pc, 32'h10C);

    // back-pressure from EX
    idle();
    bus.in_valid = 1; bus.in_rj = 2; bus.in_use_rj = 1; bus.rf_rdata1 = 32'h22;
    bus.in_pc = 32'h200; bus.in_ctrl = 32'hAB;
    tick();
    chk("bp_first_pc", bus.out_pc, 32'h200);
    bus.out_ready = 0;
    bus.in_pc = 32'h204; bus.in_ctrl = 32'hCD; bus.rf_rdata1 = 32'h33;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", bus.in_ready, 0);
      tick();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_pc_hold", bus.out_pc, 32'h200);
      chk("bp_src1_hold", bus.out_src1, 32'h22);
      chk("bp_ctrl_hold", bus.out_ctrl, 32'hAB);
    end
    bus.out_ready = 1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    tick();
    chk("bp_next_pc", bus.out_pc, 32'h204);
    chk("bp_next_src1", bus.out_src1, 32'h33);
    chk("bp_next_ctrl", bus.out_ctrl, 32'hCD);

    // flush beats an otherwise acceptable op
    bus.in_pc = 32'h300; flush = 1;
    #1;
    chk("fl_ready", bus.in_ready, 0);
    tick();
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_pc_kept", bus.out_pc, 32'h204);
    bus.ex_we = 1; bus.ex_is_load = 1; bus.ex_waddr = 2;
    tick();
    chk("fl_no_stall_count", bus.stall_cnt, exp_stall);
    flush = 0;
    tick(); exp_stall++;
    chk("fl_stall_resume", bus.stall_cnt, exp_stall);

    // asynchronous reset with an op in the EX register
    idle();
    bus.in_valid = 1; bus.in_pc = 32'h400;
    tick();
    chk("ar_valid_before", bus.out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_stall", bus.stall_cnt, 0);
    chk("ar_pc", bus.out_pc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
